game_mode_ctrl: RTL



---
 rtl/game_mode_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/game_mode_ctrl.sv
// Game sequencer: LOADING -> READY -> PLAYING -> FAIL with frame-counted timers,
// saturating score, high score tracking and a one-cycle game_start pulse.
package game_mode_pkg;
   typedef enum logic [1:0] {
      GAME_MODE_LOADING = 2'd0,
      GAME_MODE_READY   = 2'd1,
      GAME_MODE_PLAYING = 2'd2,
      GAME_MODE_FAIL    = 2'd3
   } game_mode_t;
endpackage

module game_mode_ctrl
   import game_mode_pkg::*;
#(
   parameter int LOAD_FRAMES   = 120,
   parameter int READY_LOCKOUT = 30,
   parameter int FAIL_FRAMES   = 180,
   parameter int PELLET_PTS    = 10,
   parameter int POWER_PTS     = 50,
   parameter int SCORE_MAX     = 9999
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_stb,
   input  logic        key_any,
   input  logic        pellet_eaten,
   input  logic        power_eaten,
   input  logic        player_dead,
   output game_mode_t  MODE,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic        game_start
);

   localparam logic [7:0]  LOAD_LAST  = 8'(LOAD_FRAMES - 1);
   localparam logic [7:0]  FAIL_LAST  = 8'(FAIL_FRAMES - 1);
   localparam logic [7:0]  LOCKOUT    = 8'(READY_LOCKOUT);
   localparam logic [16:0] PELLET_W   = 17'(PELLET_PTS);
   localparam logic [16:0] POWER_W    = 17'(POWER_PTS);
   localparam logic [16:0] SCORE_CAP  = 17'(SCORE_MAX);

   game_mode_t  mode_q, mode_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        key_q;
   logic        key_rise_s;
   logic [15:0] score_q, score_d;
   logic [15:0] high_score_q, high_score_d;
   logic        game_start_q, game_start_d;
   logic [16:0] score_sum_s;

   assign key_rise_s  = key_any & ~key_q;
   // 17-bit sum so the clamp below sees any overflow past SCORE_MAX
   assign score_sum_s = {1'b0, score_q}
                      + (pellet_eaten ? PELLET_W : 17'd0)
                      + (power_eaten  ? POWER_W  : 17'd0);

   // Next-state, score and high-score computation
   always_comb begin
      mode_d       = mode_q;
      score_d      = score_q;
      high_score_d = high_score_q;
      game_start_d = 1'b0;
      case (mode_q)
         GAME_MODE_LOADING: begin
            if (frame_stb && (frame_cnt_q == LOAD_LAST)) mode_d = GAME_MODE_READY;
            else                                         mode_d = GAME_MODE_LOADING;
         end
         GAME_MODE_READY: begin
            if (key_rise_s && (frame_cnt_q >= LOCKOUT)) begin
               mode_d       = GAME_MODE_PLAYING;
               score_d      = 16'd0;
               game_start_d = 1'b1;
            end else begin
               mode_d = GAME_MODE_READY;
            end
         end
         GAME_MODE_PLAYING: begin
            if (score_sum_s > SCORE_CAP) score_d = SCORE_CAP[15:0];
            else                         score_d = score_sum_s[15:0];
            // Final score already includes any points landing on the death edge
            if (player_dead) begin
               mode_d = GAME_MODE_FAIL;
               if (score_d > high_score_q) high_score_d = score_d;
               else                        high_score_d = high_score_q;
            end else begin
               mode_d = GAME_MODE_PLAYING;
            end
         end
         GAME_MODE_FAIL: begin
            if (frame_stb && (frame_cnt_q == FAIL_LAST)) mode_d = GAME_MODE_READY;
            else                                         mode_d = GAME_MODE_FAIL;
         end
         default: mode_d = GAME_MODE_LOADING;
      endcase

      if (mode_d != mode_q)                         frame_cnt_d = 8'd0;
      else if (frame_stb && (frame_cnt_q != 8'hFF)) frame_cnt_d = frame_cnt_q + 8'd1;
      else                                          frame_cnt_d = frame_cnt_q;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= GAME_MODE_LOADING;
         frame_cnt_q  <= 8'd0;
         key_q        <= 1'b0;
         score_q      <= 16'd0;
         high_score_q <= 16'd0;
         game_start_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         frame_cnt_q  <= frame_cnt_d;
         key_q        <= key_any;
         score_q      <= score_d;
         high_score_q <= high_score_d;
         game_start_q <= game_start_d;
      end
   end

   assign MODE       = mode_q;
   assign score      = score_q;
   assign high_score = high_score_q;
   assign game_start = game_start_q;

endmodule
